// File: rtl/fifo_flush_sched_if.sv
// Write-side scheduler bus: two nibble producers, the flush requester and the fifo_flush write port.
// Optional statistics outputs exist only when FIFO_FLUSH_SCHED_STATS_EN is defined.
interface fifo_flush_sched_if #(
  parameter int DATA_W = 4
);
  logic              req0_valid_i;
  logic [DATA_W-1:0] req0_data_i;
  logic              req0_ready_o;
  logic              req1_valid_i;
  logic [DATA_W-1:0] req1_data_i;
  logic              req1_ready_o;
  logic              flush_req_i;
  logic              flush_busy_o;
  logic              flush_ack_o;
  logic              flush_timeout_o;
  logic              fifo_wr_valid_o;
  logic [DATA_W-1:0] fifo_wr_data_o;
  logic              fifo_flush_o;
  logic              fifo_full_i;
  logic              fifo_flush_done_i;
`ifdef FIFO_FLUSH_SCHED_STATS_EN
  logic [7:0]        stat_wr0_o;
  logic [7:0]        stat_wr1_o;
  logic [7:0]        stat_flush_o;
`endif

  // The scheduler is the slave; producers, flush requester and FIFO status form the master side.
  modport slave (
    input  req0_valid_i, req0_data_i, req1_valid_i, req1_data_i,
    input  flush_req_i, fifo_full_i, fifo_flush_done_i,
    output req0_ready_o, req1_ready_o, flush_busy_o, flush_ack_o, flush_timeout_o,
`ifdef FIFO_FLUSH_SCHED_STATS_EN
    output stat_wr0_o, stat_wr1_o, stat_flush_o,
`endif
    output fifo_wr_valid_o, fifo_wr_data_o, fifo_flush_o
  );

  modport master (
    output req0_valid_i, req0_data_i, req1_valid_i, req1_data_i,
    output flush_req_i, fifo_full_i, fifo_flush_done_i,
    input  req0_ready_o, req1_ready_o, flush_busy_o, flush_ack_o, flush_timeout_o,
`ifdef FIFO_FLUSH_SCHED_STATS_EN
    input  stat_wr0_o, stat_wr1_o, stat_flush_o,
`endif
    input  fifo_wr_valid_o, fifo_wr_data_o, fifo_flush_o
  );
endinterface

// File: rtl/fifo_flush_sched.sv
// Round-robin arbiter of two producers onto the fifo_flush write port, plus the flush sequencer.
// Define FIFO_FLUSH_SCHED_STATS_EN to add the wrapping transfer/flush statistics counters.
module fifo_flush_sched #(
  parameter int DATA_W        = 4,
  parameter int FLUSH_TIMEOUT = 16
) (
  input logic              clock,
  input logic              reset,
  fifo_flush_sched_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(FLUSH_TIMEOUT - 1);

  state_t            state;
  logic              rr_ptr;
  logic [7:0]        flush_cnt;
  logic              flush_q;
  logic              ack_q;
  logic              busy_q;
  logic              timeout_q;
  logic              grant0;
  logic              grant1;
  logic [DATA_W-1:0] wr_data;

  // Grants are decided combinationally so the write lands on the same edge as the handshake.
  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == RUN && !bus.flush_req_i && !bus.fifo_full_i) begin
      if (bus.req0_valid_i && bus.req1_valid_i) begin
        grant0 = !rr_ptr;
        grant1 = rr_ptr;
      end else begin
        grant0 = bus.req0_valid_i;
        grant1 = bus.req1_valid_i;
      end
    end
  end

  always_comb begin
    wr_data = '0;
    if (grant0)      wr_data = bus.req0_data_i;
    else if (grant1) wr_data = bus.req1_data_i;
  end

  assign bus.req0_ready_o    = grant0;
  assign bus.req1_ready_o    = grant1;
  assign bus.fifo_wr_valid_o = grant0 | grant1;
  assign bus.fifo_wr_data_o  = wr_data;
  assign bus.fifo_flush_o    = flush_q;
  assign bus.flush_ack_o     = ack_q;
  assign bus.flush_busy_o    = busy_q;
  assign bus.flush_timeout_o = timeout_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      rr_ptr    <= 1'b0;
      flush_cnt <= '0;
      flush_q   <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state)
        RUN: begin
          if (bus.flush_req_i) begin
            state     <= FLUSH;
            flush_cnt <= '0;
            flush_q   <= 1'b1;
            busy_q    <= 1'b1;
          end else if (grant0) begin
            rr_ptr <= 1'b1;
          end else if (grant1) begin
            rr_ptr <= 1'b0;
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + 8'd1;
          // Done wins over a coincident timeout, so the sticky flag only marks genuine aborts.
          if (bus.fifo_flush_done_i || flush_cnt == TIMEOUT_LAST) begin
            state   <= ACK;
            flush_q <= 1'b0;
            ack_q   <= 1'b1;
            if (!bus.fifo_flush_done_i) timeout_q <= 1'b1;
          end
        end
        ACK: begin
          if (bus.flush_req_i) begin
            state <= RELEASE;
          end else begin
            state  <= RUN;
            busy_q <= 1'b0;
          end
        end
        RELEASE: begin
          if (!bus.flush_req_i) begin
            state  <= RUN;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_FLUSH_SCHED_STATS_EN
  logic [7:0] stat_wr0;
  logic [7:0] stat_wr1;
  logic [7:0] stat_flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_wr0   <= '0;
      stat_wr1   <= '0;
      stat_flush <= '0;
    end else begin
      if (grant0)       stat_wr0   <= stat_wr0 + 8'd1;
      if (grant1)       stat_wr1   <= stat_wr1 + 8'd1;
      if (state == ACK) stat_flush <= stat_flush + 8'd1;
    end
  end

  assign bus.stat_wr0_o   = stat_wr0;
  assign bus.stat_wr1_o   = stat_wr1;
  assign bus.stat_flush_o = stat_flush;
`endif

endmodule

// File: doc/fifo_flush_sched.md
# fifo_flush_sched

Write-side scheduler for the `fifo_flush` buffer.
- Arbitrates two nibble producers onto the FIFO's single write port with round-robin fairness.
- Sequences flush requests: blocks writes, drives the FIFO flush input, waits for flush completion, bounds the wait with a timeout, and acknowledges the requester.
- Sits directly in front of `fifo_flush`; its `fifo_*_o` outputs connect to the FIFO's `fifo_*_i` inputs.

## Interface
Parameters:
- `DATA_W`, default 4: width of producer and FIFO write data.
- `FLUSH_TIMEOUT`, default 16: maximum number of FLUSH-state cycles before a forced abort. Legal range 2..255.

Ports (`DATA_W` abbreviated to D):
- `clock`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0_valid_i`  in  1  producer 0 has data.
- `req0_data_i`  in  D  producer 0 data.
- `req0_ready_o`  out  1  producer 0 data is taken this cycle.
- `req1_valid_i`  in  1  producer 1 has data.
- `req1_data_i`  in  D  producer 1 data.
- `req1_ready_o`  out  1  producer 1 data is taken this cycle.
- `flush_req_i`  in  1  level flush request.
- `flush_busy_o`  out  1  high in every state except RUN.
- `flush_ack_o`  out  1  one-cycle pulse when a flush completes or aborts.
- `flush_timeout_o`  out  1  sticky; set on abort, cleared only by reset.
- `fifo_wr_valid_o`  out  1  FIFO write strobe.
- `fifo_wr_data_o`  out  D  FIFO write data.
- `fifo_flush_o`  out  1  FIFO flush request.
- `fifo_full_i`  in  1  FIFO full.
- `fifo_flush_done_i`  in  1  FIFO flush complete.

## Operation
States (2-bit encoding): RUN, FLUSH, ACK, RELEASE.

RUN:
- If `flush_req_i`=1: no grant this cycle; next state is FLUSH.
- Otherwise, if `fifo_full_i`=0, grant one valid requester:
  - Only one requester valid: grant that one.
  - Both valid: grant the one selected by `rr_ptr`.
- The granted requester sees ready=1. The transfer occurs when valid and ready are both high.
- On a transfer, `rr_ptr` moves to the other requester. With no transfer, `rr_ptr` holds.
- `fifo_full_i`=1: both ready outputs are 0 and `rr_ptr` holds.

FLUSH:
- `fifo_flush_o`=1 and both ready outputs are 0.
- An 8-bit cycle counter is cleared on entry and increments every cycle in FLUSH.
- `fifo_flush_done_i`=1: next state is ACK.
- Otherwise, when the counter equals `FLUSH_TIMEOUT`-1: set `flush_timeout_o`; next state is ACK.
- Done and timeout in the same cycle count as done; `flush_timeout_o` is not set.

ACK:
- `flush_ack_o`=1 for this cycle only.
- Next state is RELEASE if `flush_req_i`=1, else RUN.

RELEASE:
- Waits for `flush_req_i`=0, then returns to RUN.
- A held-high request therefore causes exactly one flush.

Datapath:
- `fifo_wr_valid_o` = transfer (req0 or req1).
- `fifo_wr_data_o` = data of the granted requester, or 0 when there is no grant.

## Timing
Reset values (asynchronous, while `reset`=0):
- State = RUN, `rr_ptr` = 0, counter = 0, `flush_timeout_o` = 0.
- All outputs 0. Ready outputs are combinational, so they reflect the inputs once the state is RUN.

Latency:
- Producer-to-FIFO path is combinational (0 cycles); the write occurs on the same edge as the producer handshake.
- Flush sequence: request seen in RUN at cycle N → FLUSH from N+1. Done asserted at cycle M → ACK at M+1 → RUN at M+2 (request already low).
- Timeout: ACK follows exactly `FLUSH_TIMEOUT` FLUSH cycles.

Boundary behaviour:
- `fifo_flush_done_i` is ignored outside FLUSH.
- `fifo_full_i` is ignored outside RUN.
- A producer may drop valid without a handshake. Its data is never written.
- Reset asserted mid-flush drops `fifo_flush_o` immediately and discards the flush without an ACK.

## Configuration
Macro `FIFO_FLUSH_SCHED_STATS_EN`.

Defined: adds three outputs.
- `stat_wr0_o` [7:0]: count of req0 transfers, wrapping at 255→0.
- `stat_wr1_o` [7:0]: count of req1 transfers, wrapping at 255→0.
- `stat_flush_o` [7:0]: count of ACK cycles, wrapping at 255→0.
- All three reset to 0.

Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Single producer: reset released; req0 streams A, 6, 8 with req1 idle, `fifo_full_i`=0 → three consecutive writes A, 6, 8; `req1_ready_o` stays 0.
- Fairness: both valid for 4 cycles, req0 data 1, req1 data 2 → write sequence 1, 2, 1, 2 (`rr_ptr` starts at 0).
- Full: `fifo_full_i`=1 with both requesters valid for 3 cycles → no writes, `rr_ptr` unchanged; writes resume on the first cycle after full drops.
- Flush with done after 3 cycles:
  - `flush_req_i` pulsed for 1 cycle while req0 is valid → no grant that cycle.
  - `fifo_flush_o` is high for 3 cycles; `flush_ack_o` pulses once.
  - `flush_timeout_o`=0, and state returns to RUN.
- Timeout: `FLUSH_TIMEOUT`=16 and done never asserted → `fifo_flush_o` high for exactly 16 cycles, then ACK, then `flush_timeout_o`=1, which stays set.
- Held request: `flush_req_i` held high for 30 cycles with done after 2 cycles → exactly one flush and one ACK, then RELEASE until the request drops.
